debounce_array: RTL



---
 rtl/debounce_pkg.sv | 13 +
 rtl/debounce_channel.sv | 125 ++++++++++++
 rtl/debounce_array.sv | 58 +++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel push-button front end.
package debounce_pkg;

  typedef enum logic [1:0] {IDLE, PRESSED, LONG} btn_state_t;

  // Counter width for a count that runs 0..max; at least one bit so a disabled (0) counter still elaborates.
  function automatic int cnt_w(input int max);
    int w;
    w = $clog2(max + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, debounce counter and press/long/repeat FSM.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int LONG_PRESS_CYCLES = 25000000,
  parameter int REPEAT_CYCLES     = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic press_set
);

  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int HW = cnt_w(LONG_PRESS_CYCLES);
  localparam int RW = cnt_w(REPEAT_CYCLES);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);
  localparam bit LONG_EN = (LONG_PRESS_CYCLES != 0);
  localparam bit REP_EN  = LONG_EN && (REPEAT_CYCLES != 0);

  logic          sync0, sync1, stable, last_stable;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt, hold_next;
  logic [RW-1:0] rep_cnt, rep_next;
  btn_state_t    state, state_next;
  logic          rise, fall, release_set, long_set, repeat_set;

  // A single cycle of agreement restarts the count, so only a level held for DEBOUNCE_CYCLES flips stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0       <= 1'b0;
      sync1       <= 1'b0;
      stable      <= 1'b0;
      last_stable <= 1'b0;
      db_cnt      <= '0;
    end else begin
      sync0       <= btn_in;
      sync1       <= sync0;
      last_stable <= stable;
      if (sync1 == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        stable <= sync1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  assign rise      = stable & ~last_stable;
  assign fall      = ~stable & last_stable;
  assign btn_level = stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      rep_cnt       <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state         <= state_next;
      hold_cnt      <= hold_next;
      rep_cnt       <= rep_next;
      press_pulse   <= press_set;
      release_pulse <= release_set;
      long_pulse    <= long_set;
      repeat_pulse  <= repeat_set;
    end
  end

  // A fall always wins, which discards any long/repeat count due in the same cycle.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    rep_next   = rep_cnt;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_next = PRESSED;
          hold_next  = '0;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_next = IDLE;
        end else if (LONG_EN) begin
          if (hold_cnt == HOLD_LAST) begin
            state_next = LONG;
            rep_next   = '0;
          end else begin
            hold_next = hold_cnt + HW'(1);
          end
        end
      end
      LONG: begin
        if (fall) begin
          state_next = IDLE;
        end else if (REP_EN) begin
          rep_next = (rep_cnt == REP_LAST) ? '0 : rep_cnt + RW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    press_set   = (state == IDLE) && rise;
    release_set = (state != IDLE) && fall;
    long_set    = LONG_EN && (state == PRESSED) && !fall && (hold_cnt == HOLD_LAST);
    repeat_set  = REP_EN && (state == LONG) && !fall && (rep_cnt == REP_LAST);
  end

endmodule

// File: rtl/debounce_array.sv
// NUM_BTN independent debounced button channels with polarity correction and a combined press strobe.
module debounce_array
  import debounce_pkg::*;
#(
  parameter int                 NUM_BTN           = 4,
  parameter int                 DEBOUNCE_CYCLES   = 250000,
  parameter int                 LONG_PRESS_CYCLES = 25000000,
  parameter int                 REPEAT_CYCLES     = 5000000,
  parameter logic [NUM_BTN-1:0] ACTIVE_LOW_MASK   = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_pulse,
  output logic [NUM_BTN-1:0] repeat_pulse,
  output logic               any_press
);

  if (NUM_BTN == 0 || DEBOUNCE_CYCLES == 0) begin : g_bad_param
    $error("debounce_array: NUM_BTN and DEBOUNCE_CYCLES must be non-zero");
  end

  logic [NUM_BTN-1:0] btn_in;
  logic [NUM_BTN-1:0] press_set;

  assign btn_in = btn_raw ^ ACTIVE_LOW_MASK;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .REPEAT_CYCLES    (REPEAT_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_in       (btn_in[g]),
      .btn_level    (btn_level[g]),
      .press_pulse  (press_pulse[g]),
      .release_pulse(release_pulse[g]),
      .long_pulse   (long_pulse[g]),
      .repeat_pulse (repeat_pulse[g]),
      .press_set    (press_set[g])
    );
  end

  // Registered from the channels' next-cycle press decisions so it lines up with press_pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |press_set;
    end
  end

endmodule
